pipeline_trace_unit: RTL and testbench
======================================

# pipeline_trace_unit

Parametrised pipeline occupancy tracker for the MIPS core test environment. It shadows the CPU pipeline cycle by cycle and follows each fetched instruction through NUM_STAGES stages, honouring stall and flush. For every instruction that completes, it emits a retire record (instruction word, fetch cycle, stall cycles) through a valid/ready FIFO, and it maintains retire/flush/drop statistics. It generalises the fixed 5-stage, stall-only tracker with configurable depth, stall/flush regions, flush support, backpressure and loss accounting.

## Interface
- NUM_STAGES, 5, pipeline depth (3..8)
- INSTR_W, 16, instruction word width
- CYC_W, 16, cycle counter / timestamp width
- STALL_W, 4, per-instruction stall counter width (saturating)
- STALL_STAGES, 2, stages 0..STALL_STAGES-1 freeze on stall (1..NUM_STAGES-1)
- FLUSH_STAGES, 2, stages 0..FLUSH_STAGES-1 killed on flush (1..NUM_STAGES-1)
- FIFO_DEPTH, 4, retire FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  instruction presented at fetch this cycle
- if_instr  in  INSTR_W  fetched instruction word
- stall  in  1  freeze front stages
- flush  in  1  kill front stages (priority over stall)
- ret_valid  out  1  FIFO head valid
- ret_ready  in  1  consumer accepts head
- ret_instr  out  INSTR_W  head instruction word
- ret_start  out  CYC_W  cycle_cnt value when instruction entered stage 0
- ret_stalls  out  STALL_W  cycles spent frozen
- in_flight  out  $clog2(NUM_STAGES+1)  valid stage count
- retired_cnt, flushed_cnt, dropped_cnt  out  16 each  saturating statistics
- overflow  out  1  sticky: a record was dropped

## Operation
- Each stage s holds v[s], instr[s], start[s], stl[s]. cycle_cnt is a free-running internal counter of width CYC_W that wraps to 0.
- Normal edge (no stall, no flush): stage s+1 ← stage s. Stage 0 ← {if_valid, if_instr, cycle_cnt, 0}.
- Stall without flush:
  - Stages 0..STALL_STAGES-1 hold their contents.
  - Each valid held entry gets stl+1, saturating at 2^STALL_W-1.
  - Stage STALL_STAGES receives a bubble (v=0).
  - Stages above STALL_STAGES advance normally.
  - if_valid is ignored; the source must re-present the instruction.
- Flush (stall is ignored):
  - Stages 0..FLUSH_STAGES-1 are invalidated.
  - Stage FLUSH_STAGES receives a bubble.
  - Stages above FLUSH_STAGES advance.
  - if_valid is discarded.
  - flushed_cnt increases by the number of valid entries killed, plus 1 if if_valid was set.
- Retire: a valid entry in stage NUM_STAGES-1 at an edge is pushed into the FIFO and retired_cnt is incremented.
- FIFO behaviour:
  - A pop (ret_valid && ret_ready) is evaluated before the push, so a push into a full FIFO with a simultaneous pop succeeds.
  - A push into a full FIFO without a pop is dropped: dropped_cnt+1, overflow←1. retired_cnt still counts the instruction.
- All counters saturate at 0xFFFF.
- in_flight equals the population count of v[].

## Timing
- Reset (async assert, sync deassert expected): all v=0, FIFO empty, cycle_cnt=0, all counts 0, overflow=0, ret_valid=0, in_flight=0. Data outputs read 0.
- Reset mid-operation discards all in-flight entries and FIFO contents immediately.
- Latency without stalls: if_valid sampled at edge k appears with ret_valid=1 after edge k+NUM_STAGES, if the FIFO was empty. ret_start equals cycle_cnt at edge k.
- Each stall cycle on an entry within the stall region adds 1 cycle of latency and 1 to ret_stalls.
- ret_valid/head fields are registered outputs. They stay stable while ret_valid && !ret_ready.
- in_flight and the statistics update on the same edge as the event that causes them.

## Test plan
- Reset, then if_valid with instructions 0x1111..0x5555 on 5 consecutive cycles -> records appear in order from cycle 5 with ret_start 0..4, ret_stalls 0, retired_cnt=5, in_flight peaks at 5.
- Stall held 3 cycles while 0xA0A0 is in stage 1 -> its record has ret_stalls=3 and arrives 3 cycles late. The instruction in stage 2 at stall onset retires unaffected, followed by a bubble.
- Flush with stages 0,1 valid and if_valid=1 -> flushed_cnt=3, only older instructions retire, in_flight drops by 2 on the next edge.
- Stall and flush asserted together -> flush behaviour only, no stall increments.
- ret_ready=0, stream 6 instructions, FIFO_DEPTH=4 -> 4 records held, dropped_cnt=2, overflow=1. Then ret_ready=1 -> the 4 records drain in order. Full FIFO with a simultaneous pop and push -> no drop.
- Assert rst_n low mid-stream with 3 in flight and 2 in FIFO -> all outputs return to reset values without a clock edge. After release, a new instruction gets ret_start=0.

Source files
------------

// File: rtl/pipeline_trace_unit.sv
// Pipeline occupancy tracker: shadows a NUM_STAGES-deep CPU pipeline under
// stall/flush and emits one retire record per completed instruction via a FIFO.
module pipeline_trace_unit #(
  parameter int NUM_STAGES   = 5,
  parameter int INSTR_W      = 16,
  parameter int CYC_W        = 16,
  parameter int STALL_W      = 4,
  parameter int STALL_STAGES = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              if_valid,
  input  logic [INSTR_W-1:0]                if_instr,
  input  logic                              stall,
  input  logic                              flush,
  output logic                              ret_valid,
  input  logic                              ret_ready,
  output logic [INSTR_W-1:0]                ret_instr,
  output logic [CYC_W-1:0]                  ret_start,
  output logic [STALL_W-1:0]                ret_stalls,
  output logic [$clog2(NUM_STAGES+1)-1:0]   in_flight,
  output logic [15:0]                       retired_cnt,
  output logic [15:0]                       flushed_cnt,
  output logic [15:0]                       dropped_cnt,
  output logic                              overflow
);

  localparam int IF_W   = $clog2(NUM_STAGES + 1);
  localparam int KILL_W = IF_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [NUM_STAGES-1:0] v, v_nxt;
  logic [INSTR_W-1:0]    instr     [NUM_STAGES];
  logic [INSTR_W-1:0]    instr_nxt [NUM_STAGES];
  logic [CYC_W-1:0]      start     [NUM_STAGES];
  logic [CYC_W-1:0]      start_nxt [NUM_STAGES];
  logic [STALL_W-1:0]    stl       [NUM_STAGES];
  logic [STALL_W-1:0]    stl_nxt   [NUM_STAGES];
  logic [CYC_W-1:0]      cycle_cnt;

  logic [KILL_W-1:0] kill_cnt;
  logic [16:0]       flush_sum;
  logic [IF_W-1:0]   in_flight_c;

  // Stage 0 is always inside both the stall and the flush region.
  always_comb begin
    v_nxt        = v;
    instr_nxt    = instr;
    start_nxt    = start;
    stl_nxt      = stl;

    if (flush) begin
      v_nxt[0] = 1'b0;
    end else if (stall) begin
      if (v[0] && stl[0] != STALL_MAX) stl_nxt[0] = stl[0] + STALL_W'(1);
    end else begin
      v_nxt[0]     = if_valid;
      instr_nxt[0] = if_instr;
      start_nxt[0] = cycle_cnt;
      stl_nxt[0]   = '0;
    end

    for (int s = 1; s < NUM_STAGES; s++) begin
      if (flush && s <= FLUSH_STAGES) begin
        v_nxt[s] = 1'b0;
      end else if (!flush && stall && s < STALL_STAGES) begin
        if (v[s] && stl[s] != STALL_MAX) stl_nxt[s] = stl[s] + STALL_W'(1);
      end else if (!flush && stall && s == STALL_STAGES) begin
        v_nxt[s] = 1'b0;
      end else begin
        v_nxt[s]     = v[s-1];
        instr_nxt[s] = instr[s-1];
        start_nxt[s] = start[s-1];
        stl_nxt[s]   = stl[s-1];
      end
    end
  end

  // A discarded fetch counts as a killed instruction too.
  always_comb begin
    kill_cnt = {{IF_W{1'b0}}, if_valid};
    for (int s = 0; s < FLUSH_STAGES; s++) begin
      kill_cnt = kill_cnt + KILL_W'(v[s]);
    end
    flush_sum = {1'b0, flushed_cnt} + 17'(kill_cnt);
  end

  always_comb begin
    in_flight_c = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      in_flight_c = in_flight_c + IF_W'(v[s]);
    end
  end

  assign in_flight = in_flight_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      cycle_cnt <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        instr[s] <= '0;
        start[s] <= '0;
        stl[s]   <= '0;
      end
    end else begin
      v         <= v_nxt;
      instr     <= instr_nxt;
      start     <= start_nxt;
      stl       <= stl_nxt;
      cycle_cnt <= cycle_cnt + CYC_W'(1);
    end
  end

  // Retire FIFO. Handshake: a record transfers on a rising edge where
  // ret_valid && ret_ready; while ret_valid && !ret_ready the head fields hold.
  // The pop is taken before the push, so a full FIFO being drained still accepts.
  logic [INSTR_W-1:0] f_instr [FIFO_DEPTH];
  logic [CYC_W-1:0]   f_start [FIFO_DEPTH];
  logic [STALL_W-1:0] f_stl   [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   f_cnt;
  logic               retire, pop, push, drop, full;

  assign retire = v[NUM_STAGES-1];
  assign full   = (f_cnt == CNT_W'(FIFO_DEPTH));
  assign pop    = ret_valid && ret_ready;
  assign push   = retire && (!full || pop);
  assign drop   = retire && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      f_instr[wr_ptr] <= instr[NUM_STAGES-1];
      f_start[wr_ptr] <= start[NUM_STAGES-1];
      f_stl[wr_ptr]   <= stl[NUM_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      f_cnt       <= '0;
      retired_cnt <= '0;
      flushed_cnt <= '0;
      dropped_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && !pop)      f_cnt <= f_cnt + CNT_W'(1);
      else if (pop && !push) f_cnt <= f_cnt - CNT_W'(1);

      if (retire && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
      if (flush) flushed_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 16'd1;
      end
    end
  end

  assign ret_valid  = (f_cnt != '0);
  assign ret_instr  = ret_valid ? f_instr[rd_ptr] : '0;
  assign ret_start  = ret_valid ? f_start[rd_ptr] : '0;
  assign ret_stalls = ret_valid ? f_stl[rd_ptr]   : '0;

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit: fill, stall, flush, stall+flush,
// backpressure with overflow, full-FIFO pop/push, and asynchronous reset.
module tb_pipeline_trace_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ret_valid;
  logic        ret_ready = 1'b0;
  logic [15:0] ret_instr;
  logic [15:0] ret_start;
  logic [3:0]  ret_stalls;
  logic [2:0]  in_flight;
  logic [15:0] retired_cnt, flushed_cnt, dropped_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];

  pipeline_trace_unit dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr),
    .stall(stall), .flush(flush),
    .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_instr(ret_instr), .ret_start(ret_start), .ret_stalls(ret_stalls),
    .in_flight(in_flight),
    .retired_cnt(retired_cnt), .flushed_cnt(flushed_cnt), .dropped_cnt(dropped_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // cyc mirrors the number of edges since reset release, i.e. the start stamp
  // an instruction driven now will receive.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic st, input logic fl);
    if_valid = v;
    if_instr = ins;
    stall    = st;
    flush    = fl;
  endtask

  task automatic check_head(input string tag, input logic [15:0] ins,
                            input int st, input logic [3:0] stl);
    check({tag, "_valid"}, ret_valid, 1);
    check({tag, "_instr"}, ret_instr, ins);
    check({tag, "_start"}, ret_start, st[15:0]);
    check({tag, "_stalls"}, ret_stalls, stl);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, ret_valid, 0);
    check({tag, "_inflight"}, in_flight, 0);
    check({tag, "_retired"}, retired_cnt, 0);
    check({tag, "_flushed"}, flushed_cnt, 0);
    check({tag, "_dropped"}, dropped_cnt, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_instr"}, ret_instr, 0);
  endtask

  int s_c, s_a, s_b, s_d1, s_d2, s_f0;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    ret_ready = 1'b1;

    // back-to-back fill: 0x1111..0x5555 stamped 0..4
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
      tick();
      check("fill_inflight", in_flight, i + 1);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head("fill_rec", 16'(16'h1111 * (i + 1)), i, 4'd0);
    end
    check("fill_retired", retired_cnt, 5);
    tick();
    check("fill_empty", ret_valid, 0);
    check("fill_inflight_end", in_flight, 0);

    // stall 3 cycles with 0xA0A0 in stage 1, 0x0C0C in stage 2
    s_c = cyc; drive(1'b1, 16'h0C0C, 1'b0, 1'b0); tick();
    s_a = cyc; drive(1'b1, 16'hA0A0, 1'b0, 1'b0); tick();
    s_b = cyc; drive(1'b1, 16'hB0B0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hDEAD, 1'b1, 1'b0);
    tick();
    check("stall_inflight", in_flight, 3);
    tick();
    tick();
    check_head("stall_older", 16'h0C0C, s_c, 4'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("stall_bubble", ret_valid, 0);
    tick();
    tick();
    check("stall_late", ret_valid, 0);
    tick();
    check_head("stall_a", 16'hA0A0, s_a, 4'd3);
    tick();
    check_head("stall_b", 16'hB0B0, s_b, 4'd3);
    tick();
    check("stall_empty", ret_valid, 0);
    check("stall_retired", retired_cnt, 8);

    // flush with stages 0,1 valid and a fetch pending
    s_d1 = cyc; drive(1'b1, 16'hD001, 1'b0, 1'b0); tick();
    s_d2 = cyc; drive(1'b1, 16'hD002, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hD003, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hD004, 1'b0, 1'b0); tick();
    check("flush_pre_inflight", in_flight, 4);
    drive(1'b1, 16'hEEEE, 1'b0, 1'b1);
    tick();
    check("flush_cnt", flushed_cnt, 3);
    check("flush_inflight", in_flight, 2);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check_head("flush_d1", 16'hD001, s_d1, 4'd0);
    tick();
    check_head("flush_d2", 16'hD002, s_d2, 4'd0);
    tick();
    check("flush_empty", ret_valid, 0);
    check("flush_retired", retired_cnt, 10);

    // stall and flush together: flush wins
    s_f0 = cyc; drive(1'b1, 16'hF000, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hF001, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hF002, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("sf_inflight", in_flight, 1);
    check("sf_flushed", flushed_cnt, 5);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check_head("sf_f0", 16'hF000, s_f0, 4'd0);
    tick();
    check("sf_empty", ret_valid, 0);
    check("sf_inflight_end", in_flight, 0);

    // backpressure: 6 records into a 4-entry FIFO
    ret_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h6001 + 16'(i), 1'b0, 1'b0);
      tick();
      if (i < 4) exp_q.push_back(16'h6001 + 16'(i));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (5) tick();
    check("bp_dropped", dropped_cnt, 2);
    check("bp_overflow", overflow, 1);
    check("bp_retired", retired_cnt, 17);
    tick();
    check("bp_hold_valid", ret_valid, 1);
    check("bp_hold_instr", ret_instr, 16'h6001);
    ret_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("bp_drain", ret_instr, exp_q.pop_front());
      tick();
    end
    check("bp_empty", ret_valid, 0);

    // full FIFO, push and pop on the same edge
    ret_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h7001 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (4) tick();
    check("full_head", ret_instr, 16'h7001);
    ret_ready = 1'b1;
    tick();
    check("full_nodrop", dropped_cnt, 2);
    for (int i = 1; i < 5; i++) begin
      check("full_drain", ret_instr, 16'h7001 + 16'(i));
      tick();
    end
    check("full_empty", ret_valid, 0);
    check("full_retired", retired_cnt, 22);

    // asynchronous reset with 3 in flight and 2 in the FIFO
    ret_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h8001 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("arst_pre_inflight", in_flight, 3);
    check("arst_pre_valid", ret_valid, 1);
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    ret_ready = 1'b1;
    drive(1'b1, 16'h9009, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (5) tick();
    check_head("arst_new", 16'h9009, 0, 4'd0);
    check("arst_retired", retired_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
